stack_cmd_master: RTL

- Initiator for the 4-bit stack bus: turns single-clock request/response handshakes into the stack's strobe protocol.
- Stack bus signals: COMMAND, INDEX, bidirectional IO_DATA, stack clock strobe, stack reset.
- Owns IO_DATA bus turnaround and keeps a shadow occupancy count.
- Sits between sequencing logic and the stack so no upstream block ever toggles the stack strobe by hand.

---
 rtl/stack_cmd_master.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/stack_cmd_master.sv
// Stack bus initiator: converts one-cycle request/response handshakes into
// the SETUP / STROBE_HI / STROBE_LO strobe sequence of the 4-bit stack bus.
// It also owns IO_DATA turnaround and tracks a shadow occupancy count.
module stack_cmd_master #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned PHASE = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [1:0] i_req_op,
    input  logic [3:0] i_req_data,
    input  logic [2:0] i_req_index,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [3:0] o_rsp_data,
    output logic       o_rsp_err,
    output logic [2:0] o_level,
    output logic [1:0] o_command,
    output logic [2:0] o_index,
    output logic       o_stk_clk,
    output logic       o_stk_reset,
    inout  wire  [3:0] io_data
);

    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned LVL_W  = 3;
    localparam int unsigned CNT_W  = 2;

    localparam logic [OP_W-1:0]  OP_RST  = 2'd0;
    localparam logic [OP_W-1:0]  OP_PUSH = 2'd1;
    localparam logic [OP_W-1:0]  OP_POP  = 2'd2;
    localparam logic [OP_W-1:0]  OP_GET  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE - 1);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE_HI,
        ST_STROBE_LO,
        ST_RESP
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [OP_W-1:0]     r_op;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_drive;
    logic [DATA_W-1:0]   r_cap;
    logic                r_err;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic [LVL_W-1:0]    r_level;
    logic [OP_W-1:0]     r_command;
    logic [IDX_W-1:0]    r_index;
    logic                r_stk_clk;
    logic                r_stk_reset;

    logic                w_accept;
    logic                w_phase_done;
    logic                w_is_read;
    logic                w_err;
    logic [LVL_W-1:0]    w_level_next;

    assign w_accept     = i_req_valid && r_req_ready;
    assign w_phase_done = (r_cnt == CNT_LAST);
    // Pop (2) and get (3) both return data from the stack.
    assign w_is_read    = r_op[1];
    // Error is judged against the occupancy seen when the request arrives.
    assign w_err        = ((i_req_op == OP_POP) && (r_level == '0)) ||
                          ((i_req_op == OP_GET) && (i_req_index >= r_level));

    // Shadow occupancy after the in-flight op takes effect.
    always_comb begin
        w_level_next = r_level;
        unique case (r_op)
            OP_RST:  w_level_next = '0;
            OP_PUSH: w_level_next = (r_level == LVL_MAX) ? r_level : r_level + LVL_W'(1);
            OP_POP:  w_level_next = (r_level == '0) ? r_level : r_level - LVL_W'(1);
            default: w_level_next = r_level;
        endcase
    end

    // Transaction sequencer with registered bus and response outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= OP_RST;
            r_wdata     <= '0;
            r_drive     <= 1'b0;
            r_cap       <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_level     <= '0;
            r_command   <= OP_RST;
            r_index     <= '0;
            r_stk_clk   <= 1'b0;
            r_stk_reset <= 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_stk_reset <= 1'b0;
                    if (w_accept) begin
                        r_op        <= i_req_op;
                        r_wdata     <= i_req_data;
                        r_err       <= w_err;
                        r_command   <= i_req_op;
                        r_index     <= i_req_index;
                        r_drive     <= (i_req_op == OP_PUSH);
                        r_stk_reset <= (i_req_op == OP_RST);
                        r_stk_clk   <= 1'b0;
                        r_req_ready <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_phase_done) begin
                        r_cnt       <= '0;
                        // A stack reset op never strobes; its reset pulse ends here.
                        r_stk_clk   <= (r_op != OP_RST);
                        r_stk_reset <= 1'b0;
                        r_state     <= ST_STROBE_HI;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STROBE_HI: begin
                    if (w_phase_done) begin
                        r_cnt     <= '0;
                        r_stk_clk <= 1'b0;
                        r_level   <= w_level_next;
                        if (w_is_read) begin
                            r_cap <= io_data;
                        end
                        r_state   <= ST_STROBE_LO;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STROBE_LO: begin
                    if (w_phase_done) begin
                        r_cnt       <= '0;
                        r_drive     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_is_read ? r_cap : '0;
                        r_rsp_err   <= r_err;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_data     = r_drive ? r_wdata : 4'bzzzz;
    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;
    assign o_level     = r_level;
    assign o_command   = r_command;
    assign o_index     = r_index;
    assign o_stk_clk   = r_stk_clk;
    assign o_stk_reset = r_stk_reset;

endmodule
